// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: accepts one instruction at a time, issues an
// aligned big-endian memory request, waits for completion or timeout, and
// retires the result into held output registers.
module mem_access_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int CTRL_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic              link,
  input  logic [CTRL_W-1:0] control,
  input  logic [REG_W-1:0]  rdIn,
  output logic              mreq,
  output logic              mwe,
  output logic [3:0]        mbe,
  output logic [DATA_W-1:0] maddr,
  output logic [DATA_W-1:0] mwdata,
  input  logic [DATA_W-1:0] mrdata,
  input  logic              mack,
  output logic              out_valid,
  output logic [DATA_W-1:0] address_out,
  output logic [DATA_W-1:0] data_out,
  output logic [DATA_W-1:0] mem_data_out,
  output logic [CTRL_W-1:0] control_out,
  output logic [REG_W-1:0]  rdOut,
  output logic [1:0]        fault
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  localparam logic [1:0] F_NONE  = 2'b00;
  localparam logic [1:0] F_ALIGN = 2'b01;
  localparam logic [1:0] F_TMO   = 2'b10;

  typedef enum logic [1:0] {IDLE, WAIT, RETIRE} state_t;

  state_t state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0] addr_q, addr_d, din_q, din_d, ldata_q, ldata_d;
  logic              link_q, link_d, uns_q, uns_d;
  logic [1:0]        size_q, size_d, pend_fault_q, pend_fault_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic              mreq_q, mreq_d, mwe_q, mwe_d;
  logic [3:0]        mbe_q, mbe_d;
  logic [DATA_W-1:0] maddr_q, maddr_d, mwdata_q, mwdata_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] address_out_q, address_out_d, data_out_q, data_out_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic [CTRL_W-1:0] control_out_q, control_out_d;
  logic [REG_W-1:0]  rd_out_q, rd_out_d;
  logic [1:0]        fault_q, fault_d;

  logic              misaligned;
  logic [3:0]        acc_mbe;
  logic [DATA_W-1:0] acc_wdata;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_value;

  // Alignment check, big-endian byte enables and lane-replicated store data
  always_comb begin
    misaligned = 1'b0;
    acc_mbe    = 4'b1111;
    acc_wdata  = data_in;
    case (size)
      SZ_BYTE: begin
        acc_mbe   = 4'b1000 >> address[1:0];
        acc_wdata = {4{data_in[7:0]}};
      end
      SZ_HALF: begin
        misaligned = address[0];
        acc_mbe    = address[1] ? 4'b0011 : 4'b1100;
        acc_wdata  = {2{data_in[15:0]}};
      end
      default: misaligned = |address[1:0];
    endcase
  end

  // Lane extraction and sign/zero extension of returned load data
  always_comb begin
    ld_byte = '0;
    case (addr_q[1:0])
      2'b00:   ld_byte = mrdata[31:24];
      2'b01:   ld_byte = mrdata[23:16];
      2'b10:   ld_byte = mrdata[15:8];
      default: ld_byte = mrdata[7:0];
    endcase
    ld_half  = addr_q[1] ? mrdata[15:0] : mrdata[31:16];
    ld_value = mrdata;
    case (size_q)
      SZ_BYTE: ld_value = uns_q ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_value = uns_q ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_value = mrdata;
    endcase
  end

  // Next-state logic: accept, wait for completion/timeout, retire
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    addr_d        = addr_q;
    din_d         = din_q;
    link_d        = link_q;
    uns_d         = uns_q;
    size_d        = size_q;
    ctrl_d        = ctrl_q;
    rd_d          = rd_q;
    pend_fault_d  = pend_fault_q;
    ldata_d       = ldata_q;
    mreq_d        = mreq_q;
    mwe_d         = mwe_q;
    mbe_d         = mbe_q;
    maddr_d       = maddr_q;
    mwdata_d      = mwdata_q;
    out_valid_d   = 1'b0;
    address_out_d = address_out_q;
    data_out_d    = data_out_q;
    mem_data_d    = mem_data_q;
    control_out_d = control_out_q;
    rd_out_d      = rd_out_q;
    fault_d       = fault_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          addr_d       = address;
          din_d        = data_in;
          link_d       = link;
          uns_d        = is_unsigned;
          size_d       = size;
          ctrl_d       = control;
          rd_d         = rdIn;
          ldata_d      = '0;
          wait_cnt_d   = '0;
          pend_fault_d = F_NONE;
          state_d      = RETIRE;
          if (mem_rd || mem_wr) begin
            if (misaligned) begin
              pend_fault_d = F_ALIGN;
            end else begin
              state_d  = WAIT;
              mreq_d   = 1'b1;
              mwe_d    = mem_wr;
              mbe_d    = acc_mbe;
              maddr_d  = {address[DATA_W-1:2], 2'b00};
              mwdata_d = acc_wdata;
            end
          end
        end
      end
      WAIT: begin
        // Completion wins over a timeout landing on the same cycle
        if (mack) begin
          mreq_d  = 1'b0;
          mwe_d   = 1'b0;
          mbe_d   = '0;
          state_d = RETIRE;
          if (!mwe_q) ldata_d = ld_value;
        end else if (wait_cnt_q == CNT_LAST) begin
          mreq_d       = 1'b0;
          mwe_d        = 1'b0;
          mbe_d        = '0;
          pend_fault_d = F_TMO;
          state_d      = RETIRE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      RETIRE: begin
        state_d       = IDLE;
        out_valid_d   = 1'b1;
        address_out_d = addr_q;
        data_out_d    = link_q ? din_q : addr_q;
        mem_data_d    = ldata_q;
        control_out_d = (pend_fault_q != F_NONE) ? '0 : ctrl_q;
        rd_out_d      = (pend_fault_q != F_NONE) ? '0 : rd_q;
        fault_d       = pend_fault_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous active-low clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      wait_cnt_q    <= '0;
      addr_q        <= '0;
      din_q         <= '0;
      link_q        <= 1'b0;
      uns_q         <= 1'b0;
      size_q        <= '0;
      ctrl_q        <= '0;
      rd_q          <= '0;
      pend_fault_q  <= '0;
      ldata_q       <= '0;
      mreq_q        <= 1'b0;
      mwe_q         <= 1'b0;
      mbe_q         <= '0;
      maddr_q       <= '0;
      mwdata_q      <= '0;
      out_valid_q   <= 1'b0;
      address_out_q <= '0;
      data_out_q    <= '0;
      mem_data_q    <= '0;
      control_out_q <= '0;
      rd_out_q      <= '0;
      fault_q       <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      addr_q        <= addr_d;
      din_q         <= din_d;
      link_q        <= link_d;
      uns_q         <= uns_d;
      size_q        <= size_d;
      ctrl_q        <= ctrl_d;
      rd_q          <= rd_d;
      pend_fault_q  <= pend_fault_d;
      ldata_q       <= ldata_d;
      mreq_q        <= mreq_d;
      mwe_q         <= mwe_d;
      mbe_q         <= mbe_d;
      maddr_q       <= maddr_d;
      mwdata_q      <= mwdata_d;
      out_valid_q   <= out_valid_d;
      address_out_q <= address_out_d;
      data_out_q    <= data_out_d;
      mem_data_q    <= mem_data_d;
      control_out_q <= control_out_d;
      rd_out_q      <= rd_out_d;
      fault_q       <= fault_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign mreq         = mreq_q;
  assign mwe          = mwe_q;
  assign mbe          = mbe_q;
  assign maddr        = maddr_q;
  assign mwdata       = mwdata_q;
  assign out_valid    = out_valid_q;
  assign address_out  = address_out_q;
  assign data_out     = data_out_q;
  assign mem_data_out = mem_data_q;
  assign control_out  = control_out_q;
  assign rdOut        = rd_out_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: expected retire records are queued when
// an instruction is driven and compared when out_valid appears.
module tb_mem_access_stage;

  localparam int TMO = 15;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] address = '0, data_in = '0;
  logic        mem_rd = 1'b0, mem_wr = 1'b0;
  logic [1:0]  size = '0;
  logic        is_unsigned = 1'b0, link = 1'b0;
  logic [15:0] control = '0;
  logic [4:0]  rdIn = '0;
  logic        mreq, mwe;
  logic [3:0]  mbe;
  logic [31:0] maddr, mwdata;
  logic [31:0] mrdata = '0;
  logic        mack = 1'b0;
  logic        out_valid;
  logic [31:0] address_out, data_out, mem_data_out;
  logic [15:0] control_out;
  logic [4:0]  rdOut;
  logic [1:0]  fault;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] mdata;
    logic        chk_mdata;
    logic [15:0] ctrl;
    logic [4:0]  rd;
    logic [1:0]  fault;
  } exp_t;

  exp_t exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  mem_access_stage #(.DATA_W(32), .REG_W(5), .CTRL_W(16), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .address(address), .data_in(data_in), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .size(size), .is_unsigned(is_unsigned), .link(link), .control(control),
    .rdIn(rdIn), .mreq(mreq), .mwe(mwe), .mbe(mbe), .maddr(maddr),
    .mwdata(mwdata), .mrdata(mrdata), .mack(mack), .out_valid(out_valid),
    .address_out(address_out), .data_out(data_out), .mem_data_out(mem_data_out),
    .control_out(control_out), .rdOut(rdOut), .fault(fault)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] ld_model(input logic [1:0] sz, input logic [31:0] a,
                                           input logic uns, input logic [31:0] rdata);
    int sh;
    logic [31:0] v;
    if (sz == 2'b00) begin
      sh = (3 - int'(a[1:0])) * 8;
      v  = (rdata >> sh) & 32'h0000_00FF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      sh = a[1] ? 0 : 16;
      v  = (rdata >> sh) & 32'h0000_FFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  // Drive one instruction, play the memory side, then check the retire record.
  // mack_cyc counts cycles after the accept edge; 0 means memory never answers.
  task automatic run_instr(input string tag, input logic rd_i, input logic wr_i,
                           input logic [1:0] sz, input logic uns, input logic lnk,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [15:0] c, input logic [4:0] r,
                           input int mack_cyc, input logic [31:0] rdata);
    logic        is_mem, misal, to, ok;
    int          last_wait, lat, cyc;
    logic [3:0]  byte_one, e_mbe;
    logic [31:0] e_wdata;
    exp_t        e, got;
    is_mem   = rd_i | wr_i;
    misal    = is_mem && ((sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00));
    ok       = is_mem && !misal;
    to       = ok && (mack_cyc == 0 || mack_cyc > TMO);
    last_wait = !ok ? 0 : (to ? TMO : mack_cyc);
    lat      = ok ? last_wait + 2 : 2;
    byte_one = 4'b1000;
    e_mbe    = (sz == 2'b00) ? (byte_one >> a[1:0]) :
               (sz == 2'b01) ? (a[1] ? 4'b0011 : 4'b1100) : 4'b1111;
    e_wdata  = (sz == 2'b00) ? {4{d[7:0]}} : (sz == 2'b01) ? {2{d[15:0]}} : d;
    e.addr      = a;
    e.data      = lnk ? d : a;
    e.fault     = misal ? 2'b01 : (to ? 2'b10 : 2'b00);
    e.ctrl      = (e.fault != 2'b00) ? 16'h0 : c;
    e.rd        = (e.fault != 2'b00) ? 5'h0 : r;
    e.chk_mdata = ok && rd_i && !wr_i && !to;
    e.mdata     = ld_model(sz, a, uns, rdata);
    exp_q.push_back(e);

    @(negedge clock);
    chk({tag, ".in_ready_idle"}, in_ready, 1);
    in_valid = 1'b1; mem_rd = rd_i; mem_wr = wr_i; size = sz; is_unsigned = uns;
    link = lnk; address = a; data_in = d; control = c; rdIn = r;
    @(negedge clock);
    // Scramble inputs after the accept so only latched values can retire
    in_valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; size = ~sz; is_unsigned = ~uns;
    link = ~lnk; address = ~a; data_in = ~d; control = ~c; rdIn = ~r;
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      chk({tag, ".in_ready_busy"}, in_ready, 0);
      if (ok) begin
        chk({tag, ".mreq"}, mreq, (cyc <= last_wait) ? 1 : 0);
        if (cyc == 1) begin
          chk({tag, ".mwe"}, mwe, wr_i);
          chk({tag, ".mbe"}, mbe, e_mbe);
          chk({tag, ".maddr"}, maddr, {a[31:2], 2'b00});
          if (wr_i) chk({tag, ".mwdata"}, mwdata, e_wdata);
        end
      end else if (cyc == 1) begin
        chk({tag, ".no_mreq"}, mreq, 0);
      end
      mack   = (cyc == mack_cyc);
      mrdata = (cyc == mack_cyc) ? rdata : 32'hDEAD_BEEF;
      @(negedge clock);
      cyc++;
    end
    mack = 1'b0;
    mrdata = 32'hDEAD_BEEF;
    chk({tag, ".retire_seen"}, out_valid, 1);
    chk({tag, ".latency"}, cyc, lat);
    got = exp_q.pop_front();
    chk({tag, ".address_out"}, address_out, got.addr);
    chk({tag, ".data_out"}, data_out, got.data);
    chk({tag, ".control_out"}, control_out, got.ctrl);
    chk({tag, ".rdOut"}, rdOut, got.rd);
    chk({tag, ".fault"}, fault, got.fault);
    if (got.chk_mdata) chk({tag, ".mem_data_out"}, mem_data_out, got.mdata);
    @(negedge clock);
    chk({tag, ".out_valid_drop"}, out_valid, 0);
    chk({tag, ".data_hold"}, data_out, got.data);
    chk({tag, ".fault_hold"}, fault, got.fault);
  endtask

  initial begin
    mrdata = 32'hDEAD_BEEF;
    repeat (2) @(negedge clock);
    chk("rst.mreq", mreq, 0);
    chk("rst.mwe", mwe, 0);
    chk("rst.mbe", mbe, 0);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.fault", fault, 0);
    chk("rst.data_out", data_out, 0);
    chk("rst.control_out", control_out, 0);
    chk("rst.rdOut", rdOut, 0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst.in_ready", in_ready, 1);

    // tag, rd, wr, size, uns, link, addr, data, ctrl, rd, mack_cyc, mrdata
    run_instr("link",     0, 0, 2'b10, 0, 1, 32'h0000_0010, 32'h0040_0008, 16'hA5A5, 5'd7, 0, '0);
    run_instr("alu",      0, 0, 2'b10, 0, 0, 32'h0000_1234, 32'h5555_AAAA, 16'h0F0F, 5'd3, 0, '0);
    run_instr("sb",       0, 1, 2'b00, 0, 0, 32'h0000_0102, 32'h0000_00AB, 16'h1111, 5'd0, 3, '0);
    run_instr("lh_s",     1, 0, 2'b01, 0, 0, 32'h0000_0006, 32'h0,        16'h2222, 5'd9, 2, 32'h1234_F00D);
    run_instr("lh_u",     1, 0, 2'b01, 1, 0, 32'h0000_0006, 32'h0,        16'h2223, 5'd9, 2, 32'h1234_F00D);
    run_instr("lb_s",     1, 0, 2'b00, 0, 0, 32'h0000_0001, 32'h0,        16'h3333, 5'd4, 1, 32'h1280_3456);
    run_instr("lw",       1, 0, 2'b10, 0, 0, 32'h0000_0008, 32'h0,        16'h4444, 5'd5, 4, 32'h89AB_CDEF);
    run_instr("lw_misal", 1, 0, 2'b10, 0, 0, 32'h0000_0002, 32'h0,        16'h5555, 5'd6, 2, 32'h1111_1111);
    run_instr("sh_misal", 0, 1, 2'b01, 0, 0, 32'h0000_0003, 32'h1234_5678, 16'h6666, 5'd8, 2, '0);
    run_instr("sh",       0, 1, 2'b01, 0, 0, 32'h0000_0202, 32'h1234_BEEF, 16'h7777, 5'd1, 1, '0);
    run_instr("rdwr",     1, 1, 2'b10, 0, 0, 32'h0000_0300, 32'hCAFE_F00D, 16'h8888, 5'd2, 2, 32'h0BAD_0BAD);
    run_instr("tmo",      1, 0, 2'b10, 0, 0, 32'h0000_0400, 32'h0,        16'h9999, 5'd10, 0, '0);
    run_instr("ack15",    1, 0, 2'b10, 0, 0, 32'h0000_0404, 32'h0,        16'hAAAA, 5'd11, TMO, 32'h7654_3210);

    // Reset in the middle of a WAIT, then a stale mack that must be ignored
    @(negedge clock);
    in_valid = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0; size = 2'b10; address = 32'h0000_0040;
    control = 16'hBBBB; rdIn = 5'd12; link = 1'b0;
    @(negedge clock);
    in_valid = 1'b0; mem_rd = 1'b0;
    chk("rstwait.mreq_c1", mreq, 1);
    @(negedge clock);
    chk("rstwait.mreq_c2", mreq, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rstwait.mreq_async", mreq, 0);
    chk("rstwait.in_ready", in_ready, 1);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    @(negedge clock);
    mack = 1'b1; mrdata = 32'h1357_9BDF;
    @(negedge clock);
    mack = 1'b0; mrdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      chk("rstwait.no_out_valid", out_valid, 0);
      chk("rstwait.no_mreq", mreq, 0);
      @(negedge clock);
    end

    run_instr("lb_u_after", 1, 0, 2'b00, 1, 0, 32'h0000_0503, 32'h0, 16'hCCCC, 5'd13, 2, 32'h0000_00C3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
